wptr_side_rptr_decoder: RTL

Write-clock-domain receiver for the FIFO read pointer. It synchronizes the Gray-coded read pointer from the read domain, decodes it to binary, and computes the registered write-side fill level with an almost-full flag. Two sticky integrity checks flag a non-Gray pointer jump and an impossible fill level. It sits beside the write pointer handler and supplies `g_rptr_sync` for the full comparison, plus level and status for the write-side producer.

---
 rtl/wptr_side_rptr_decoder_if.sv | 39 +++
 rtl/wptr_side_rptr_decoder.sv | 106 ++++++++++
 2 files changed

// File: rtl/wptr_side_rptr_decoder_if.sv
// Signal bundle between the write-side producer/pointer logic and the read-pointer receiver.
// The master drives the raw pointers and error clear; the slave returns synchronized status.
interface wptr_side_rptr_decoder_if #(
    parameter int PTR_WIDTH = 3
);
    logic [PTR_WIDTH:0] g_rptr;
    logic [PTR_WIDTH:0] b_wptr;
    logic               err_clr;
    logic [PTR_WIDTH:0] g_rptr_sync;
    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] wlevel;
    logic               almost_full;
    logic               gray_err;
    logic               lvl_err;

    modport master (
        output g_rptr,
        output b_wptr,
        output err_clr,
        input  g_rptr_sync,
        input  b_rptr_sync,
        input  wlevel,
        input  almost_full,
        input  gray_err,
        input  lvl_err
    );

    modport slave (
        input  g_rptr,
        input  b_wptr,
        input  err_clr,
        output g_rptr_sync,
        output b_rptr_sync,
        output wlevel,
        output almost_full,
        output gray_err,
        output lvl_err
    );
endinterface

// File: rtl/wptr_side_rptr_decoder.sv
// Write-domain receiver for the Gray read pointer: synchronizes, decodes, and derives
// a pessimistic fill level with almost-full and two sticky integrity flags.
module wptr_side_rptr_decoder #(
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    wptr_side_rptr_decoder_if.slave bus
);
    localparam int W = PTR_WIDTH + 1;
    localparam logic [W-1:0] ZERO_W    = {W{1'b0}};
    localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] DEPTH_LVL = {1'b1, {PTR_WIDTH{1'b0}}};
    localparam logic [W-1:0] AF_LVL    = W'(AF_THRESH);

    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic multi_bit(input logic [W-1:0] d);
        return ((d & (d - ONE_W)) != ZERO_W);
    endfunction

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0] g_prev_q, g_prev_d;
    logic [W-1:0] b_rptr_q, b_rptr_d;
    logic [W-1:0] wlevel_q, wlevel_d;
    logic         almost_full_q, almost_full_d;
    logic         gray_err_q, gray_err_d;
    logic         lvl_err_q, lvl_err_d;

    logic [W-1:0] g_sync_s;
    logic [W-1:0] lvl_next_s;
    logic         gray_hit_s;
    logic         lvl_hit_s;

    assign g_sync_s = sync_q[SYNC_STAGES-1];

    // Next-state for the synchronizer chain, decode and level path.
    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.g_rptr};
        g_prev_d      = g_sync_s;
        b_rptr_d      = gray_to_bin(g_sync_s);
        lvl_next_s    = bus.b_wptr - b_rptr_q;
        wlevel_d      = lvl_next_s;
        almost_full_d = (lvl_next_s >= AF_LVL);
    end

    // Sticky error flags; a fresh detection outranks a simultaneous clear.
    always_comb begin
        gray_hit_s = multi_bit(g_sync_s ^ g_prev_q);
        lvl_hit_s  = (lvl_next_s > DEPTH_LVL);
        gray_err_d = gray_err_q;
        lvl_err_d  = lvl_err_q;
        if (gray_hit_s) begin
            gray_err_d = 1'b1;
        end else if (bus.err_clr) begin
            gray_err_d = 1'b0;
        end else begin
            gray_err_d = gray_err_q;
        end
        if (lvl_hit_s) begin
            lvl_err_d = 1'b1;
        end else if (bus.err_clr) begin
            lvl_err_d = 1'b0;
        end else begin
            lvl_err_d = lvl_err_q;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q        <= '0;
            g_prev_q      <= ZERO_W;
            b_rptr_q      <= ZERO_W;
            wlevel_q      <= ZERO_W;
            almost_full_q <= 1'b0;
            gray_err_q    <= 1'b0;
            lvl_err_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            g_prev_q      <= g_prev_d;
            b_rptr_q      <= b_rptr_d;
            wlevel_q      <= wlevel_d;
            almost_full_q <= almost_full_d;
            gray_err_q    <= gray_err_d;
            lvl_err_q     <= lvl_err_d;
        end
    end

    assign bus.g_rptr_sync = g_sync_s;
    assign bus.b_rptr_sync = b_rptr_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.almost_full = almost_full_q;
    assign bus.gray_err    = gray_err_q;
    assign bus.lvl_err     = lvl_err_q;

endmodule
